conv2d_scheduler: RTL

Sequencing controller for the conv2d MAC datapath. On start it walks every neuron, output row and output column, and for each output pixel issues one input read and one weight address per tap (channel, kernel row, kernel column). It marks the first and last tap for the accumulator, then presents each finished result's output address with a valid/ready handshake. It sits between input feature-map RAM, kernel RAM, the MAC datapath and the output buffer.

---
 rtl/conv_pkg.sv | 24 ++
 rtl/conv2d_scheduler_if.sv | 34 +++
 rtl/conv_tap_addr_gen.sv | 56 +++++
 rtl/conv2d_scheduler.sv | 127 ++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// conv_pkg: shared state encoding and geometry helpers for the conv2d scheduler
package conv_pkg;

    typedef enum logic [2:0] {IDLE, FETCH, DRAIN, EMIT, DONE} state_t;

    // Counter and address width: clog2 of the range, never below one bit
    function automatic int cw(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction

    // Output edge length for a fully covered input edge
    function automatic int out_dim(input int d, input int k, input int s);
        return (d - k) / s + 1;
    endfunction

    function automatic int taps(input int ic, input int k);
        return ic * k * k;
    endfunction

    localparam int OUT_W = out_dim(64, 3, 1);
    localparam int OUT_H = out_dim(64, 3, 1);
    localparam int TAPS  = taps(1, 3);

endpackage

// File: rtl/conv2d_scheduler_if.sv
// conv2d_scheduler_if: control, RAM address and result handshake bundle of the scheduler
interface conv2d_scheduler_if
    import conv_pkg::*;
#(
    parameter int IAW = cw(64 * 64 * 1),
    parameter int WAW = cw(TAPS * 30),
    parameter int OAW = cw(OUT_W * OUT_H * 30)
) ();
    logic           start;
    logic           enable;
    logic           busy;
    logic           done;
    logic           in_rd_en;
    logic [IAW-1:0] in_addr;
    logic [WAW-1:0] w_addr;
    logic           mac_valid;
    logic           mac_first;
    logic           mac_last;
    logic           out_valid;
    logic [OAW-1:0] out_addr;
    logic           out_ready;

    modport master (
        input  start, enable, out_ready,
        output busy, done, in_rd_en, in_addr, w_addr,
               mac_valid, mac_first, mac_last, out_valid, out_addr
    );

    modport slave (
        output start, enable, out_ready,
        input  busy, done, in_rd_en, in_addr, w_addr,
               mac_valid, mac_first, mac_last, out_valid, out_addr
    );
endinterface

// File: rtl/conv_tap_addr_gen.sv
// conv_tap_addr_gen: c/i/j tap walker producing the input and kernel address of the next tap
module conv_tap_addr_gen
    import conv_pkg::*;
#(
    parameter int IW  = 64,
    parameter int IH  = 64,
    parameter int IC  = 1,
    parameter int K   = 3,
    parameter int IAW = 12,
    parameter int WAW = 9
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           clear,
    input  logic           advance,
    input  logic [IAW-1:0] in_base,
    input  logic [WAW-1:0] w_base,
    output logic [IAW-1:0] in_tap,
    output logic [WAW-1:0] w_tap,
    output logic           first_tap,
    output logic           last_tap
);
    localparam int CW = cw(IC);
    localparam int KW = cw(K);

    logic [CW-1:0] c;
    logic [KW-1:0] i, j;
    logic          c_end, i_end, j_end;

    // Tap position flags and window base plus channel-major tap offset
    always_comb begin
        j_end     = j == KW'(K - 1);
        i_end     = i == KW'(K - 1);
        c_end     = c == CW'(IC - 1);
        first_tap = (c == '0) && (i == '0) && (j == '0);
        last_tap  = c_end && i_end && j_end;
        in_tap    = in_base + IAW'(32'(c) * IW * IH + 32'(i) * IW + 32'(j));
        w_tap     = w_base + WAW'(32'(c) * K * K + 32'(i) * K + 32'(j));
    end

    // j innermost, then i, then c; wraps to tap 0 after the last tap of a window
    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            c <= '0;
            i <= '0;
            j <= '0;
        end else if (advance) begin
            j <= j_end ? '0 : j + KW'(1);
            if (j_end) begin
                i <= i_end ? '0 : i + KW'(1);
                if (i_end) c <= c_end ? '0 : c + CW'(1);
            end
        end
    end

endmodule

// File: rtl/conv2d_scheduler.sv
// conv2d_scheduler: layer-pass FSM, window counters and registered MAC/output strobes
module conv2d_scheduler
    import conv_pkg::*;
#(
    parameter int INPUT_WIDTH    = 64,
    parameter int INPUT_HEIGHT   = 64,
    parameter int INPUT_CHANNELS = 1,
    parameter int WINDOW_SIZE    = 3,
    parameter int NUM_NEURONS    = 30,
    parameter int STRIDE         = 1
) (
    input logic                clk,
    input logic                reset_n,
    conv2d_scheduler_if.master bus
);
    localparam int OW  = out_dim(INPUT_WIDTH, WINDOW_SIZE, STRIDE);
    localparam int OH  = out_dim(INPUT_HEIGHT, WINDOW_SIZE, STRIDE);
    localparam int T   = taps(INPUT_CHANNELS, WINDOW_SIZE);
    localparam int IAW = cw(INPUT_WIDTH * INPUT_HEIGHT * INPUT_CHANNELS);
    localparam int WAW = cw(T * NUM_NEURONS);
    localparam int OAW = cw(OW * OH * NUM_NEURONS);
    localparam int XW  = cw(OW);
    localparam int YW  = cw(OH);
    localparam int NW  = cw(NUM_NEURONS);

    state_t         state, state_n;
    logic           issue, first_tap, last_tap, tap_first_q, tap_last_q;
    logic           ox_end, oy_end, n_end, win_last, last_win;
    logic [XW-1:0]  ox;
    logic [YW-1:0]  oy;
    logic [NW-1:0]  n;
    logic [IAW-1:0] in_base, in_tap;
    logic [WAW-1:0] w_base, w_tap;

    conv_tap_addr_gen #(
        .IW (INPUT_WIDTH),
        .IH (INPUT_HEIGHT),
        .IC (INPUT_CHANNELS),
        .K  (WINDOW_SIZE),
        .IAW(IAW),
        .WAW(WAW)
    ) u_tap (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (state == DONE),
        .advance  (issue),
        .in_base  (in_base),
        .w_base   (w_base),
        .in_tap   (in_tap),
        .w_tap    (w_tap),
        .first_tap(first_tap),
        .last_tap (last_tap)
    );

    // State register
    always_ff @(posedge clk) state <= !reset_n ? IDLE : state_n;

    // Next state: FETCH leaves once the last tap of the window is on the bus
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = bus.start ? FETCH : IDLE;
            FETCH:   state_n = tap_last_q ? DRAIN : FETCH;
            DRAIN:   state_n = EMIT;
            EMIT:    state_n = !bus.out_ready ? EMIT : last_win ? DONE : FETCH;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Output decode: a tap issues on every edge that lands in FETCH with enable high
    always_comb begin
        issue    = bus.enable && state_n == FETCH;
        ox_end   = ox == XW'(OW - 1);
        oy_end   = oy == YW'(OH - 1);
        n_end    = n == NW'(NUM_NEURONS - 1);
        win_last = ox_end && oy_end && n_end;
        in_base  = IAW'(32'(oy) * STRIDE * INPUT_WIDTH + 32'(ox) * STRIDE);
        w_base   = WAW'(32'(n) * T);
    end

    // Registered strobes and addresses; the window advances in DRAIN so EMIT can restart FETCH directly
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.in_rd_en  <= 1'b0;
            bus.in_addr   <= '0;
            bus.w_addr    <= '0;
            bus.mac_valid <= 1'b0;
            bus.mac_first <= 1'b0;
            bus.mac_last  <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_addr  <= '0;
            tap_first_q   <= 1'b0;
            tap_last_q    <= 1'b0;
            last_win      <= 1'b0;
            ox            <= '0;
            oy            <= '0;
            n             <= '0;
        end else begin
            bus.busy      <= state_n != IDLE;
            bus.done      <= state_n == DONE;
            bus.out_valid <= state_n == EMIT;
            bus.in_rd_en  <= issue;
            tap_first_q   <= issue && first_tap;
            tap_last_q    <= issue && last_tap;
            bus.mac_valid <= bus.in_rd_en;
            bus.mac_first <= tap_first_q;
            bus.mac_last  <= tap_last_q;
            if (issue) begin
                bus.in_addr <= in_tap;
                bus.w_addr  <= w_tap;
            end
            if (state == DRAIN) begin
                bus.out_addr <= OAW'(32'(n) * OW * OH + 32'(oy) * OW + 32'(ox));
                last_win     <= win_last;
                ox           <= ox_end ? '0 : ox + XW'(1);
                if (ox_end) begin
                    oy <= oy_end ? '0 : oy + YW'(1);
                    if (oy_end) n <= n_end ? '0 : n + NW'(1);
                end
            end
        end
    end

endmodule
